ram_moc_controller: RTL and testbench
=====================================

Name: ram_moc_controller

Overview:
- Memory-side stage directly downstream of the processor control unit.
- Accepts a memory request from the control unit and services it against an internal byte-addressable RAM. The request is MFA asserted with RW, DataType, Address and DataIn.
- After a fixed access latency it performs the access and asserts MOC (memory operation complete). The control unit's MOC wait states consume MOC.
- All word and halfword accesses are big-endian.

Parameters:
- ADDR_W, 8, byte-address width; RAM depth is 2**ADDR_W bytes.
- LATENCY, 2, edges from request capture to MOC assertion; legal range is 1..15.

Ports:
- Clk  in  1  clock; rising edge is active.
- Clr  in  1  reset; asynchronous, active-low.
- MFA  in  1  memory function activate. The control unit holds it high until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- DataType  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  write data, right-justified for byte/halfword.
- DataOut  out  32  read data, zero-extended for byte/halfword.
- MOC  out  1  operation complete; registered.
- Busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (Clr=0, asynchronous): state = IDLE, MOC = 0, Busy = 0, DataOut = 0, latency counter = 0. RAM contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with MFA=1, capture RW, DataType, Address and DataIn into request registers.
  - Load cnt = LATENCY-1 and go to BUSY.
  - Inputs are ignored after capture.
- BUSY:
  - On an edge with MFA=0 (abort): go to IDLE, perform no access, RAM is unchanged.
  - Else if cnt==0: perform the access and go to DONE; MOC=1 is registered on this same edge.
  - Else: cnt <= cnt-1.
- Latency: MOC first rises on the edge LATENCY cycles after the capture edge.
- DONE:
  - MOC stays 1 while MFA=1.
  - On an edge with MFA=0: MOC <= 0 and go to IDLE.
  - A new request requires at least one IDLE edge; back-to-back requests never skip IDLE.
- Alignment: the captured address is forced aligned. Halfword ignores bit 0; word ignores bits 1:0. No error is raised.
- Read data, with a = aligned address:
  - Byte: DataOut = {24'b0, mem[a]}.
  - Halfword: DataOut = {16'b0, mem[a], mem[a+1]}.
  - Word: DataOut = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- DataOut loads on the DONE-entry edge of a read only. It holds through writes, aborts and idle until the next read completes.
- Writes:
  - Byte: mem[a] = DataIn[7:0].
  - Halfword: mem[a] = DataIn[15:8], mem[a+1] = DataIn[7:0].
  - Word: mem[a..a+3] = DataIn[31:24], DataIn[23:16], DataIn[15:8], DataIn[7:0].
  - The write commits once, on the DONE-entry edge.
- Address bounds: the address is ADDR_W bits wide, so it wraps naturally. An aligned access can never straddle the top of memory.
- Reset asserted mid-operation (BUSY or DONE): return to IDLE and drop MOC immediately. A write that has not reached DONE entry is discarded.
- MFA rising in the same cycle that Clr deasserts: the request is captured on the first edge with Clr=1.

Decomposition:
- Shared package, usable by the control unit:
  - DataType encodings: DT_BYTE, DT_HALF, DT_WORD.
  - RW encodings: RW_READ = 1, RW_WRITE = 0.
  - FSM state encodings: IDLE, BUSY, DONE.
- One sub-module, ram_byte_array:
  - Synchronous write port with 4-lane byte enables, using lane index plus aligned base.
  - Combinational 4-byte big-endian read of a..a+3.
  - No reset.
  - Includes a hook for $readmemb preload by the bench.
- The FSM, latency counter and byte-lane formatting stay in ram_moc_controller.

Test Plan:
- Word write then read, LATENCY=2: write 0xDEADBEEF to addr 0x10. MOC rises 2 edges after capture. A following word read of 0x10 returns DataOut = 0xDEADBEEF. Byte reads of 0x10 and 0x13 return 0x000000DE and 0x000000EF.
- Halfword and alignment: halfword write of 0x1234 to addr 0x21 (aligned to 0x20). Word read of 0x20 returns 0x1234xxxx, where xxxx is the preloaded content of bytes 0x22–0x23. Halfword read of 0x20 returns 0x00001234.
- Handshake hold: keep MFA=1 for 5 cycles after MOC rises. MOC stays 1 and exactly one write occurs. When MFA drops, MOC falls on the next edge and Busy goes to 0.
- Abort: start a word write of 0xCAFEF00D to 0x40, then drop MFA while in BUSY. FSM returns to IDLE, MOC never rises, and a read of 0x40 returns the old content.
- Reset mid-write: assert Clr=0 during BUSY of a write of 0x11223344 to 0x08. MOC=0 and DataOut=0 immediately, and mem[0x08..0x0B] is unchanged.
- Back-to-back: keep MFA high across two requests. A second capture occurs only after MOC has dropped and one IDLE edge has passed. DataOut holds the first read value during the intervening write.

Source files
------------

// File: rtl/ram_moc_controller_pkg.sv
// Shared encodings for the memory request path.
// Both the control unit and the memory-side controller use these.
package ram_moc_controller_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Byte lanes touched by an access.
  // Lane 0 is the byte at the aligned base, which is the most significant byte.
  function automatic logic [3:0] lane_enables(input logic [1:0] dt);
    logic [3:0] be;
    case (dt)
      DT_BYTE: be = 4'b0001;
      DT_HALF: be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ram_moc_controller_if.sv
// Request/response bus between the control unit (master) and the memory controller (slave).
interface ram_moc_controller_if #(
  parameter int ADDR_W = 8
);
  logic              MFA;
  logic              RW;
  logic [1:0]        DataType;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              Busy;

  modport master (
    output MFA, RW, DataType, Address, DataIn,
    input  DataOut, MOC, Busy
  );

  modport slave (
    input  MFA, RW, DataType, Address, DataIn,
    output DataOut, MOC, Busy
  );
endinterface

// File: rtl/ram_moc_controller_ram_byte_array.sv
// Byte-addressable RAM with a 4-lane write port and a big-endian 4-byte read window.
// The array is named mem so that a bench can preload it by hierarchical path
// (for example on u_ram.mem). It has no reset, so its contents
// survive a controller reset.
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] base,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [7:0] mem [0:(2**ADDR_W)-1];

  // Write the enabled lanes; lane i lands at base+i and takes the i-th byte from the top.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[base + ADDR_W'(i)] <= wdata[8*(3-i) +: 8];
      end
    end
  end

  // The address wraps naturally at the top of memory.
  assign rdata = {mem[base],
                  mem[base + ADDR_W'(1)],
                  mem[base + ADDR_W'(2)],
                  mem[base + ADDR_W'(3)]};
endmodule

// File: rtl/ram_moc_controller.sv
// Memory-side stage: captures a request from the control unit, waits a fixed
// latency, performs one big-endian access and then holds MOC until MFA drops.
module ram_moc_controller
  import ram_moc_controller_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Clr,
  ram_moc_controller_if.slave  bus
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              capture_s, access_s, moc_s;
  logic              rw_r;
  logic [1:0]        dt_r;
  logic [ADDR_W-1:0] addr_r, aligned_s;
  logic [31:0]       din_r, wdata_s, rdata_s, rfmt_s, dout_r;
  logic              moc_r, busy_r;

  // Force the incoming address onto the natural boundary of its access size.
  always_comb begin
    aligned_s = bus.Address;
    if (bus.DataType == DT_BYTE) begin
      aligned_s = bus.Address;
    end else if (bus.DataType == DT_HALF) begin
      aligned_s[0] = 1'b0;
    end else begin
      aligned_s[1:0] = 2'b00;
    end
  end

  // Next-state, latency counter and access strobe.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    access_s  = 1'b0;
    moc_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.MFA) begin
          capture_s = 1'b1;
          cnt_s     = LAT_M1;
          state_s   = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!bus.MFA) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          moc_s    = 1'b1;
          state_s  = DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        if (!bus.MFA) begin
          state_s = IDLE;
        end else begin
          moc_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Right-justified write data moved into the big-endian lanes starting at lane 0.
  always_comb begin
    case (dt_r)
      DT_BYTE: wdata_s = {din_r[7:0], 24'h000000};
      DT_HALF: wdata_s = {din_r[15:0], 16'h0000};
      default: wdata_s = din_r;
    endcase
  end

  // Zero-extend the read window down to the access size.
  always_comb begin
    case (dt_r)
      DT_BYTE: rfmt_s = {24'h000000, rdata_s[31:24]};
      DT_HALF: rfmt_s = {16'h0000, rdata_s[31:16]};
      default: rfmt_s = rdata_s;
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= RW_READ;
      dt_r    <= DT_BYTE;
      addr_r  <= '0;
      din_r   <= 32'h00000000;
      dout_r  <= 32'h00000000;
      moc_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      moc_r   <= moc_s;
      busy_r  <= (state_s != IDLE);
      if (capture_s) begin
        rw_r   <= bus.RW;
        dt_r   <= bus.DataType;
        addr_r <= aligned_s;
        din_r  <= bus.DataIn;
      end
      if (access_s && (rw_r == RW_READ)) begin
        dout_r <= rfmt_s;
      end
    end
  end

  ram_byte_array #(.ADDR_W(ADDR_W)) u_ram (
    .Clk   (Clk),
    .we    (access_s && (rw_r == RW_WRITE)),
    .be    (lane_enables(dt_r)),
    .base  (addr_r),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  assign bus.DataOut = dout_r;
  assign bus.MOC     = moc_r;
  assign bus.Busy    = busy_r;
endmodule

// File: tb/tb_ram_moc_controller.sv
// Self-checking bench for ram_moc_controller: byte-array model plus a queue of
// expected read data, popped when MOC rises.
module tb_ram_moc_controller;
  import ram_moc_controller_pkg::*;

  localparam int LATENCY = 2;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  ram_moc_controller_if #(.ADDR_W(8)) bus ();

  ram_moc_controller #(.ADDR_W(8), .LATENCY(LATENCY)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [7:0]  mm [256];
  logic [31:0] sb [$];
  logic [31:0] last_rd = 32'h0;
  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] dt, input logic [7:0] addr);
    logic [7:0] a;
    if (dt == DT_BYTE) begin
      a = addr;
      return {24'h0, mm[a]};
    end else if (dt == DT_HALF) begin
      a = {addr[7:1], 1'b0};
      return {16'h0, mm[a], mm[a + 8'd1]};
    end else begin
      a = {addr[7:2], 2'b00};
      return {mm[a], mm[a + 8'd1], mm[a + 8'd2], mm[a + 8'd3]};
    end
  endfunction

  task automatic model_wr(input logic [1:0] dt, input logic [7:0] addr, input logic [31:0] d);
    logic [7:0] a;
    if (dt == DT_BYTE) begin
      mm[addr] = d[7:0];
    end else if (dt == DT_HALF) begin
      a = {addr[7:1], 1'b0};
      mm[a] = d[15:8];
      mm[a + 8'd1] = d[7:0];
    end else begin
      a = {addr[7:2], 2'b00};
      mm[a] = d[31:24];
      mm[a + 8'd1] = d[23:16];
      mm[a + 8'd2] = d[15:8];
      mm[a + 8'd3] = d[7:0];
    end
  endtask

  // One full handshake. Request inputs are scrambled right after capture;
  // MFA is held 'hold' extra cycles after MOC and then dropped for one edge.
  task automatic req(input logic rw, input logic [1:0] dt, input logic [7:0] addr,
                     input logic [31:0] data, input int hold, input logic rel_clr);
    int n;
    logic [31:0] exp;
    @(negedge Clk);
    if (rel_clr) Clr = 1'b1;
    bus.RW = rw; bus.DataType = dt; bus.Address = addr; bus.DataIn = data; bus.MFA = 1'b1;
    if (rw == RW_READ) sb.push_back(model_rd(dt, addr));
    @(posedge Clk); #1;
    chk("busy_after_capture", 32'(bus.Busy), 32'd1);
    chk("moc_after_capture", 32'(bus.MOC), 32'd0);
    bus.RW = ~rw; bus.DataType = ~dt; bus.Address = addr ^ 8'h80; bus.DataIn = ~data;
    n = 0;
    do begin
      @(posedge Clk); #1; n++;
    end while (!bus.MOC && n < 20);
    chk("moc_latency", 32'(n), 32'(LATENCY));
    if (rw == RW_READ) begin
      exp = sb.pop_front();
      chk("read_data", bus.DataOut, exp);
      last_rd = exp;
    end else begin
      model_wr(dt, addr, data);
      chk("dataout_hold_on_write", bus.DataOut, last_rd);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("moc_held", 32'(bus.MOC), 32'd1);
      chk("busy_held", 32'(bus.Busy), 32'd1);
    end
    @(negedge Clk);
    bus.MFA = 1'b0;
    @(posedge Clk); #1;
    chk("moc_drop", 32'(bus.MOC), 32'd0);
    chk("busy_drop", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MFA = 1'b0; bus.RW = RW_READ; bus.DataType = DT_BYTE;
    bus.Address = 8'h00; bus.DataIn = 32'h0;
    #1;
    chk("reset_moc", 32'(bus.MOC), 32'd0);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_dataout", bus.DataOut, 32'd0);
    #20;
    @(negedge Clk);
    Clr = 1'b1;

    // Preload every byte through the DUT so the model knows the whole array.
    for (int k = 0; k < 64; k++) begin
      req(RW_WRITE, DT_WORD, 8'(k * 4), $urandom, 0, 1'b0);
    end

    // Word write then word and byte reads.
    req(RW_WRITE, DT_WORD, 8'h10, 32'hDEADBEEF, 0, 1'b0);
    req(RW_READ,  DT_WORD, 8'h10, 32'h0, 0, 1'b0);
    chk("word_read_10", bus.DataOut, 32'hDEADBEEF);
    req(RW_READ,  DT_BYTE, 8'h10, 32'h0, 0, 1'b0);
    chk("byte_read_10", bus.DataOut, 32'h000000DE);
    req(RW_READ,  DT_BYTE, 8'h13, 32'h0, 0, 1'b0);
    chk("byte_read_13", bus.DataOut, 32'h000000EF);

    // Halfword write to an odd address aligns down.
    req(RW_WRITE, DT_HALF, 8'h21, 32'hFFFF1234, 0, 1'b0);
    req(RW_READ,  DT_WORD, 8'h22, 32'h0, 0, 1'b0);
    chk("word_read_20_top", {16'h0, bus.DataOut[31:16]}, 32'h00001234);
    req(RW_READ,  DT_HALF, 8'h20, 32'h0, 0, 1'b0);
    chk("half_read_20", bus.DataOut, 32'h00001234);
    req(RW_READ,  DT_HALF, 8'h21, 32'h0, 0, 1'b0);

    // MFA held after MOC: exactly one write with the captured data.
    req(RW_WRITE, DT_BYTE, 8'h30, 32'h0000005A, 5, 1'b0);
    req(RW_READ,  DT_WORD, 8'h30, 32'h0, 0, 1'b0);

    // Abort during BUSY leaves memory untouched.
    @(negedge Clk);
    bus.RW = RW_WRITE; bus.DataType = DT_WORD; bus.Address = 8'h40;
    bus.DataIn = 32'hCAFEF00D; bus.MFA = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.MFA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("abort_moc", 32'(bus.MOC), 32'd0);
      chk("abort_busy", 32'(bus.Busy), 32'd0);
    end
    req(RW_READ, DT_WORD, 8'h40, 32'h0, 0, 1'b0);

    // Reset during BUSY of a write discards it; request rises as reset releases.
    @(negedge Clk);
    bus.RW = RW_WRITE; bus.DataType = DT_WORD; bus.Address = 8'h08;
    bus.DataIn = 32'h11223344; bus.MFA = 1'b1;
    @(posedge Clk);
    #3;
    Clr = 1'b0;
    #1;
    chk("rst_mid_moc", 32'(bus.MOC), 32'd0);
    chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
    chk("rst_mid_dataout", bus.DataOut, 32'd0);
    last_rd = 32'h0;
    bus.MFA = 1'b0;
    req(RW_READ, DT_WORD, 8'h08, 32'h0, 0, 1'b1);

    // Back-to-back: read then write with only the mandatory idle edge between.
    req(RW_READ,  DT_WORD, 8'h10, 32'h0, 2, 1'b0);
    req(RW_WRITE, DT_WORD, 8'h44, 32'h0BADF00D, 0, 1'b0);
    chk("b2b_dataout_hold", bus.DataOut, 32'hDEADBEEF);
    req(RW_READ,  DT_WORD, 8'h44, 32'h0, 0, 1'b0);

    // Top of memory: word read at 0xFF aligns to 0xFC, byte at 0xFF.
    req(RW_READ, DT_WORD, 8'hFF, 32'h0, 0, 1'b0);
    req(RW_WRITE, DT_BYTE, 8'hFF, 32'h000000A7, 0, 1'b0);
    req(RW_READ, DT_BYTE, 8'hFF, 32'h0, 0, 1'b0);
    chk("byte_read_ff", bus.DataOut, 32'h000000A7);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
